spkr_dac_spi: RTL and testbench

//  Output stage downstream of the 4-channel speaker inverter. Snapshots four 12-bit inverted samples.

---
 rtl/spkr_dac_pkg.sv | 30 +++
 rtl/spkr_dac_tick_gen.sv | 36 +++
 rtl/spkr_dac_spi.sv | 206 ++++++++++++++++++++
 tb/tb_spkr_dac_spi.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spkr_dac_pkg.sv
// Shared types and constants for the speaker DAC SPI output stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spkr_dac_pkg;

   localparam int unsigned FRAME_W = 16;
   localparam int unsigned DATA_W  = 12;
   localparam int unsigned NUM_CH  = 4;

   // Buffered reference, 1x gain, channel active.
   localparam logic [1:0] CFG_BITS_DEF = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_LDAC  = 3'd4
   } state_t;

   // DAC command word: channel address, config bits, then the 12-bit code.
   function automatic logic [FRAME_W-1:0] make_word(
      input logic [1:0]        idx,
      input logic [1:0]        cfg,
      input logic [DATA_W-1:0] data
   );
      return {idx, cfg, data};
   endfunction

endpackage

// File: rtl/spkr_dac_tick_gen.sv
// Tick divider: one-clk tick pulse every CLK_DIV clks, restartable by a synchronous clear.
// Latency: first tick CLK_DIV clks after the last clear edge.
// Backpressure: none; free-running whenever clr is low.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   clr    in  synchronous clear, counter forced to 0 on this edge
//   tick   out high for one clk when the counter reaches CLK_DIV-1
module spkr_dac_tick_gen #(
   parameter int unsigned CLK_DIV = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/spkr_dac_spi.sv
// Snapshots four inverted speaker samples, sends them as four 16-bit SPI frames, then pulses LDAC.
// Latency: LDAC falls 133*CLK_DIV+4 clks and frame_done rises 134*CLK_DIV+4 clks after the accept edge.
// Backpressure: ready low while busy; strobes seen with ready low are dropped and counted (saturating).
//
// Ports:
//   clk, rst_n                 system clock, synchronous active-low reset
//   sample_valid, ch0..ch3     one-clk strobe with four 12-bit samples
//   ready, frame_done          idle indication, one-clk pulse on LDAC release
//   overrun_cnt                dropped-strobe count, saturates at 255, cleared only by reset
//   dac_sclk/mosi/cs_n/ldac_n  SPI mode 0 to the quad DAC plus its load strobe
module spkr_dac_spi
   import spkr_dac_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 5,
   parameter logic [1:0]  CFG_BITS = CFG_BITS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] ch0,
   input  logic [DATA_W-1:0] ch1,
   input  logic [DATA_W-1:0] ch2,
   input  logic [DATA_W-1:0] ch3,
   output logic              ready,
   output logic              frame_done,
   output logic [7:0]        overrun_cnt,
   output logic              dac_sclk,
   output logic              dac_mosi,
   output logic              dac_cs_n,
   output logic              dac_ldac_n
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);
   localparam logic [1:0] LAST_CH  = 2'(NUM_CH - 1);

   state_t state_q, state_d;

   logic [NUM_CH-1:0][DATA_W-1:0] samp_q, samp_d;
   logic [1:0]                    ch_idx_q, ch_idx_d;
   logic [3:0]                    bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0]            shreg_q, shreg_d;
   logic                          tail_q, tail_d;
   logic                          ready_q, ready_d;
   logic                          frame_done_q, frame_done_d;
   logic [7:0]                    ovr_q, ovr_d;
   logic                          sclk_q, sclk_d;
   logic                          mosi_q, mosi_d;
   logic                          cs_n_q, cs_n_d;
   logic                          ldac_n_q, ldac_n_d;
   logic [FRAME_W-1:0]            load_word;
   logic                          tick;

   // Divider restarts while in LOAD so every channel's SCLK phase is identical.
   spkr_dac_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == ST_LOAD),
      .tick  (tick)
   );

   // State and registered datapath/outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         samp_q       <= '0;
         ch_idx_q     <= '0;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         tail_q       <= 1'b0;
         ready_q      <= 1'b1;
         frame_done_q <= 1'b0;
         ovr_q        <= '0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         cs_n_q       <= 1'b1;
         ldac_n_q     <= 1'b1;
      end else begin
         state_q      <= state_d;
         samp_q       <= samp_d;
         ch_idx_q     <= ch_idx_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         tail_q       <= tail_d;
         ready_q      <= ready_d;
         frame_done_q <= frame_done_d;
         ovr_q        <= ovr_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         cs_n_q       <= cs_n_d;
         ldac_n_q     <= ldac_n_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (sample_valid) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_SHIFT;
         ST_SHIFT: if (tick && sclk_q && (bit_cnt_q == LAST_BIT)) state_d = ST_GAP;
         ST_GAP: begin
            if (tick) begin
               if (ch_idx_q != LAST_CH) begin
                  state_d = ST_LOAD;
               end else if (tail_q) begin
                  state_d = ST_LDAC;
               end
            end
         end
         ST_LDAC:  if (tick) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Next values for the datapath and the registered outputs.
   always_comb begin
      samp_d       = samp_q;
      ch_idx_d     = ch_idx_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      tail_d       = tail_q;
      ready_d      = ready_q;
      frame_done_d = 1'b0;
      ovr_d        = ovr_q;
      sclk_d       = sclk_q;
      mosi_d       = mosi_q;
      cs_n_d       = cs_n_q;
      ldac_n_d     = ldac_n_q;
      load_word    = make_word(ch_idx_q, CFG_BITS, samp_q[ch_idx_q]);

      // ready is registered, so the frame_done edge itself still counts as busy.
      if (sample_valid && !ready_q && (ovr_q != 8'hFF)) begin
         ovr_d = ovr_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (sample_valid) begin
               samp_d   = {ch3, ch2, ch1, ch0};
               ch_idx_d = '0;
               tail_d   = 1'b0;
               ready_d  = 1'b0;
            end
         end
         ST_LOAD: begin
            shreg_d   = load_word;
            mosi_d    = load_word[FRAME_W-1];
            cs_n_d    = 1'b0;
            sclk_d    = 1'b0;
            bit_cnt_d = '0;
         end
         ST_SHIFT: begin
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Falling toggle: present the next bit, or close the frame after bit 0.
                  sclk_d = 1'b0;
                  if (bit_cnt_q == LAST_BIT) begin
                     cs_n_d = 1'b1;
                     mosi_d = 1'b0;
                  end else begin
                     shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                     mosi_d    = shreg_q[FRAME_W-2];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
         end
         ST_GAP: begin
            // After the last channel CS stays high for a second tick before LDAC,
            // so the DAC has settled the final word before the simultaneous update.
            if (tick) begin
               if (ch_idx_q != LAST_CH) begin
                  ch_idx_d = ch_idx_q + 2'd1;
               end else if (tail_q) begin
                  ldac_n_d = 1'b0;
               end else begin
                  tail_d = 1'b1;
               end
            end
         end
         ST_LDAC: begin
            if (tick) begin
               ldac_n_d     = 1'b1;
               frame_done_d = 1'b1;
               ready_d      = 1'b1;
            end
         end
         default: begin
            ready_d = 1'b1;
         end
      endcase
   end

   assign ready       = ready_q;
   assign frame_done  = frame_done_q;
   assign overrun_cnt = ovr_q;
   assign dac_sclk    = sclk_q;
   assign dac_mosi    = mosi_q;
   assign dac_cs_n    = cs_n_q;
   assign dac_ldac_n  = ldac_n_q;

endmodule

// File: tb/tb_spkr_dac_spi.sv
// Bench for spkr_dac_spi: two instances (CLK_DIV=2 and CLK_DIV=1) sharing one SPI monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_spkr_dac_spi;

   logic        clk;
   logic        rst_n;
   logic        sv2, sv1;
   logic [11:0] ch0, ch1, ch2, ch3;

   logic       rdy2, fd2, sclk2, mosi2, cs2, ldac2;
   logic       rdy1, fd1, sclk1, mosi1, cs1, ldac1;
   logic [7:0] ovr2, ovr1;

   spkr_dac_spi #(.CLK_DIV(2), .CFG_BITS(2'b11)) dut2 (
      .clk(clk), .rst_n(rst_n), .sample_valid(sv2),
      .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
      .ready(rdy2), .frame_done(fd2), .overrun_cnt(ovr2),
      .dac_sclk(sclk2), .dac_mosi(mosi2), .dac_cs_n(cs2), .dac_ldac_n(ldac2)
   );

   spkr_dac_spi #(.CLK_DIV(1), .CFG_BITS(2'b11)) dut1 (
      .clk(clk), .rst_n(rst_n), .sample_valid(sv1),
      .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
      .ready(rdy1), .frame_done(fd1), .overrun_cnt(ovr1),
      .dac_sclk(sclk1), .dac_mosi(mosi1), .dac_cs_n(cs1), .dac_ldac_n(ldac1)
   );

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   logic sel = 1'b0;   // 0: monitor dut2, 1: monitor dut1

   logic [15:0] expq[$];

   // monitor state
   logic        p_sclk = 1'b0, p_cs = 1'b1, p_ldac = 1'b1, p_mosi = 1'b0;
   logic [15:0] shw = '0;
   int          rises = 0;
   int          ldac_cyc = 0, fd_cyc = 0, fd_cnt = 0;

   int acc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      nvec++;
      if (obs !== exp_v) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   function automatic logic [15:0] word_of(input int idx, input logic [11:0] d);
      logic [1:0] a;
      a = 2'(idx);
      return {a, 2'b11, d};
   endfunction

   // SPI monitor: decodes frames on SCLK rises, checks framing rules, scoreboards words.
   always @(negedge clk) begin
      logic m_sclk, m_mosi, m_cs, m_ldac, m_fd;
      logic [15:0] w;
      m_sclk = sel ? sclk1 : sclk2;
      m_mosi = sel ? mosi1 : mosi2;
      m_cs   = sel ? cs1   : cs2;
      m_ldac = sel ? ldac1 : ldac2;
      m_fd   = sel ? fd1   : fd2;
      if (!rst_n) begin
         p_sclk = 1'b0; p_cs = 1'b1; p_ldac = 1'b1; p_mosi = 1'b0;
         rises  = 0;    shw  = '0;
      end else begin
         if (p_cs && !m_cs) begin
            chk("sclk_at_cs_fall", m_sclk, 1'b0);
            rises = 0;
            shw   = '0;
         end
         if (!m_cs && !p_sclk && m_sclk) begin
            chk("mosi_stable", m_mosi, p_mosi);
            shw   = {shw[14:0], p_mosi};
            rises = rises + 1;
         end
         if (!p_cs && m_cs) begin
            chk("sclk_at_cs_rise", m_sclk, 1'b0);
            chk("rises_per_frame", rises, 16);
            if (expq.size() > 0) begin
               w = expq.pop_front();
               chk("spi_word", shw, w);
            end else begin
               chk("unexpected_word", shw, 32'hDEAD_0000);
            end
         end
         if (p_ldac && !m_ldac) ldac_cyc = cyc;
         if (m_fd) begin
            fd_cyc = cyc;
            fd_cnt = fd_cnt + 1;
         end
         p_sclk = m_sclk; p_cs = m_cs; p_ldac = m_ldac; p_mosi = m_mosi;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Drive one accepted sample set; caller guarantees ready is high.
   task automatic start_frame(input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] d);
      ch0 = a; ch1 = b; ch2 = c; ch3 = d;
      expq.push_back(word_of(0, a));
      expq.push_back(word_of(1, b));
      expq.push_back(word_of(2, c));
      expq.push_back(word_of(3, d));
      if (sel) sv1 = 1'b1; else sv2 = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      sv1 = 1'b0;
      sv2 = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int n;
      n = 0;
      while (fd_cnt == prev && n < 3000) begin
         step();
         n++;
      end
      chk("frame_done_seen", fd_cnt, prev + 1);
   endtask

   initial begin
      int prev;
      int n;
      rst_n = 1'b0; sv1 = 1'b0; sv2 = 1'b0;
      ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0;
      repeat (3) @(posedge clk);
      step();

      // reset state
      chk("rst_ready", rdy2, 1'b1);
      chk("rst_frame_done", fd2, 1'b0);
      chk("rst_overrun", ovr2, 8'd0);
      chk("rst_sclk", sclk2, 1'b0);
      chk("rst_mosi", mosi2, 1'b0);
      chk("rst_cs_n", cs2, 1'b1);
      chk("rst_ldac_n", ldac2, 1'b1);
      rst_n = 1'b1;
      step();

      // basic frame, D=2
      prev = fd_cnt;
      start_frame(12'h000, 12'hFFF, 12'hA5A, 12'h5A5);
      wait_done(prev);
      chk("ldac_fall_edge", ldac_cyc - acc, 270);
      chk("frame_done_edge", fd_cyc - acc, 272);
      chk("ready_back", rdy2, 1'b1);
      chk("ldac_released", ldac2, 1'b1);
      step();
      chk("frame_done_1clk", fd2, 1'b0);

      // overrun: 3 strobes mid-frame, inputs scrambled during the frame
      prev = fd_cnt;
      start_frame(12'h123, 12'h456, 12'h789, 12'hABC);
      repeat (10) step();
      for (int i = 0; i < 3; i++) begin
         sv2 = 1'b1;
         ch0 = 12'($urandom); ch1 = 12'($urandom); ch2 = 12'($urandom); ch3 = 12'($urandom);
         step();
         sv2 = 1'b0;
         step();
      end
      wait_done(prev);
      chk("overrun_3", ovr2, 8'd3);

      // saturation: 260 + 40 more dropped strobes
      step();
      prev = fd_cnt;
      start_frame(12'h0F0, 12'hF0F, 12'h001, 12'h800);
      step();
      sv2 = 1'b1;
      repeat (260) step();
      sv2 = 1'b0;
      wait_done(prev);
      chk("overrun_sat_a", ovr2, 8'd255);
      step();
      prev = fd_cnt;
      start_frame(12'h111, 12'h222, 12'h333, 12'h444);
      step();
      sv2 = 1'b1;
      repeat (40) step();
      sv2 = 1'b0;
      wait_done(prev);
      chk("overrun_sat_b", ovr2, 8'd255);

      // reset mid-frame at channel 2, bit 7
      step();
      prev = fd_cnt;
      start_frame(12'hCAF, 12'hE12, 12'h345, 12'h678);
      while (cyc < acc + 164) step();
      chk("pre_rst_cs_low", cs2, 1'b0);
      rst_n = 1'b0;
      step();
      chk("abort_cs_n", cs2, 1'b1);
      chk("abort_sclk", sclk2, 1'b0);
      chk("abort_ldac_n", ldac2, 1'b1);
      chk("abort_ready", rdy2, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      expq.delete();
      repeat (300) step();
      chk("abort_no_done", fd_cnt, prev);
      chk("abort_ovr_clr", ovr2, 8'd0);
      prev = fd_cnt;
      start_frame(12'hFED, 12'hCBA, 12'h987, 12'h654);
      wait_done(prev);
      chk("post_rst_done_edge", fd_cyc - acc, 272);

      // D=1 back-to-back, inputs toggled while shifting
      step();
      sel = 1'b1;
      step();
      for (int f = 0; f < 3; f++) begin
         n = 0;
         while (!rdy1 && n < 500) begin
            step();
            n++;
         end
         chk("d1_ready", rdy1, 1'b1);
         prev = fd_cnt;
         if (f > 0) begin
            start_frame(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
            chk("d1_b2b_accept", acc - fd_cyc, 1);
         end else begin
            start_frame(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
         end
         repeat (40) begin
            ch0 = 12'($urandom); ch1 = 12'($urandom); ch2 = 12'($urandom); ch3 = 12'($urandom);
            step();
         end
         wait_done(prev);
         chk("d1_frame_len", fd_cyc - acc, 138);
         chk("d1_ldac_fall", ldac_cyc - acc, 137);
      end
      chk("d1_no_overrun", ovr1, 8'd0);
      repeat (5) step();
      chk("queue_drained", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
